regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_SRC writeback sources (ALU, load unit, mul/div) using round-robin arbitration with a valid/ready handshake.
- Drives the register file write port from a registered output stage.
- Keeps a per-register pending-write scoreboard that issue logic queries for RAW hazards on rs1/rs2.
- Sits between the execute/memory units and the register file.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..8)
XLEN, 32, data width, equal to the register file operand width
REG_ID_W, 5, register index width; 32 architectural registers, x0 hardwired zero

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; asynchronous, active-high
src_valid  in  NUM_SRC  per-source writeback request
src_ready  out  NUM_SRC  per-source grant; handshake completes when valid&ready
src_rd  in  NUM_SRC*REG_ID_W  destination register per source; slice i is source i
src_data  in  NUM_SRC*XLEN  writeback data per source
claim_valid  in  1  issue stage marks a destination register as pending
claim_rd  in  REG_ID_W  register being claimed
query_rs1  in  REG_ID_W  hazard query 1
query_rs2  in  REG_ID_W  hazard query 2
rs1_busy  out  1  query_rs1 has an outstanding write
rs2_busy  out  1  query_rs2 has an outstanding write
wr_en  out  1  register file write enable
wr_id  out  REG_ID_W  register file write index
wr_data  out  XLEN  register file write data

Behaviour:
- Reset (async, rst=1):
  - wr_en=0, wr_id=0, wr_data=0; busy vector all 0.
  - Round-robin pointer last_grant=NUM_SRC-1, so source 0 has first priority.
  - src_ready=0 while rst asserted.
  - An in-flight registered write is dropped; no write reaches the register file.
- Arbitration (combinational on src_valid and last_grant):
  - At most one src_ready bit high per cycle.
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_SRC; the first valid source wins.
  - No valid sources: src_ready=0, pointer unchanged.
  - On a handshake from source g, last_grant <= g.
  - Bounded wait: a continuously valid source is granted within NUM_SRC cycles.
- Source protocol:
  - Once src_valid[i] rises, src_rd/src_data slice i stay stable until the handshake.
  - The arbiter never drops or reorders a granted request.
  - src_ready may depend combinationally on src_valid; src_valid must not depend on src_ready.
- Output stage, 1-cycle latency:
  - A handshake in cycle N with rd!=0 gives wr_en=1, wr_id=rd, wr_data=data in cycle N+1.
  - With no handshake in cycle N, wr_en=0 in N+1; wr_id/wr_data hold their last value.
  - A handshake with rd=0 completes normally but leaves wr_en=0 in N+1 and does not touch the scoreboard.
- Scoreboard, busy[31:0] registered:
  - claim_valid with claim_rd!=0 sets busy[claim_rd] at the next edge.
  - A cycle with wr_en=1 clears busy[wr_id] at the next edge.
  - Claim and clear on the same register in the same cycle: the set wins and busy stays 1, because a newer producer is in flight.
  - Claim and clear on different registers in the same cycle: both take effect.
  - busy[0] is constant 0; claims of x0 are ignored.
  - Claiming an already-busy register leaves busy=1 (single-outstanding model).
  - Issue logic must not issue a second writer to a busy rd.
- Hazard query (combinational):
  - rsK_busy = busy[query_rsK] && !(wr_en && wr_id==query_rsK).
  - The register file forwards same-cycle write data, so a write in progress is not a hazard.
  - query of x0 always returns 0.
- Widths: src slice i is src_rd[i*REG_ID_W +: REG_ID_W] and src_data[i*XLEN +: XLEN]. No arithmetic on data; the pointer wraps modulo NUM_SRC.

Test Plan:
1. Assert rst mid-run with a pending write (wr_en would be 1 next cycle) -> immediately wr_en=0, wr_id=0, wr_data=0, rs1_busy=rs2_busy=0, src_ready=0; after release, source 0 wins the first contention.
2. Only src_valid[1]=1, rd=5, data=0xDEADBEEF in cycle N -> src_ready=3'b010 in N; in N+1 wr_en=1, wr_id=5, wr_data=0xDEADBEEF; in N+2 wr_en=0.
3. All three sources continuously valid from reset, each with a distinct rd -> grants 0,1,2,0,1,2 in consecutive cycles; wr_id sequence follows one cycle later; never two ready bits high.
4. Claim rd=7 in cycle N with query_rs1=7 -> rs1_busy=1 from N+1. Source 2 writes rd=7, wr_en in cycle M -> rs1_busy=0 in M (bypass) and stays 0 in M+1.
5. Claim rd=9 in the same cycle wr_en=1, wr_id=9 -> busy[9] stays 1 and rs2_busy (query 9) is 1 next cycle. Claim rd=0 -> rs1_busy for query 0 stays 0.
6. Source 0 handshakes rd=0, data=0x1234 -> src_ready[0]=1, wr_en stays 0 next cycle, scoreboard unchanged.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory units, the issue stage and the register file write port.
// The arbiter sits on the slave side; sources, issue logic and the register file sit on the master side.
interface regfile_wb_arbiter_if #(
   parameter int NUM_SRC  = 3,
   parameter int XLEN     = 32,
   parameter int REG_ID_W = 5
);
   logic [NUM_SRC-1:0]          src_valid;
   logic [NUM_SRC-1:0]          src_ready;
   logic [NUM_SRC*REG_ID_W-1:0] src_rd;
   logic [NUM_SRC*XLEN-1:0]     src_data;
   logic                        claim_valid;
   logic [REG_ID_W-1:0]         claim_rd;
   logic [REG_ID_W-1:0]         query_rs1;
   logic [REG_ID_W-1:0]         query_rs2;
   logic                        rs1_busy;
   logic                        rs2_busy;
   logic                        wr_en;
   logic [REG_ID_W-1:0]         wr_id;
   logic [XLEN-1:0]             wr_data;

   modport master (
      output src_valid, src_rd, src_data, claim_valid, claim_rd, query_rs1, query_rs2,
      input  src_ready, rs1_busy, rs2_busy, wr_en, wr_id, wr_data
   );

   modport slave (
      input  src_valid, src_rd, src_data, claim_valid, claim_rd, query_rs1, query_rs2,
      output src_ready, rs1_busy, rs2_busy, wr_en, wr_id, wr_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_SRC writeback sources,
// with a registered write stage and a pending-write scoreboard for RAW hazard queries.
module regfile_wb_arbiter #(
   parameter int NUM_SRC  = 3,
   parameter int XLEN     = 32,
   parameter int REG_ID_W = 5
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int               PTR_W    = $clog2(NUM_SRC);
   localparam int               NUM_REGS = 1 << REG_ID_W;
   localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SRC - 1);

   logic [PTR_W-1:0]    last_grant;
   logic [PTR_W-1:0]    grant_idx;
   logic [PTR_W:0]      cand;
   logic [NUM_SRC-1:0]  grant_oh;
   logic                grant_any;
   logic                handshake;
   logic [REG_ID_W-1:0] sel_rd;
   logic [XLEN-1:0]     sel_data;
   logic                wr_en_q;
   logic [REG_ID_W-1:0] wr_id_q;
   logic [XLEN-1:0]     wr_data_q;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;

   // Search starts just past the last winner and wraps, so a waiting source is served within NUM_SRC cycles.
   always_comb begin
      grant_oh  = '0;
      grant_idx = last_grant;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = {1'b0, last_grant} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_SRC)) begin
            cand = cand - (PTR_W+1)'(NUM_SRC);
         end
         if (!grant_any && bus.src_valid[cand[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end
      end
      if (grant_any) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_oh[i]) begin
            sel_rd   = bus.src_rd[i*REG_ID_W +: REG_ID_W];
            sel_data = bus.src_data[i*XLEN +: XLEN];
         end
      end
   end

   assign handshake     = grant_any && !rst;
   assign bus.src_ready = rst ? '0 : grant_oh;

   // Writes to x0 complete the handshake but never reach the register file; id/data hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= LAST_SRC;
         wr_en_q    <= 1'b0;
         wr_id_q    <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q <= handshake && (sel_rd != '0);
         if (handshake) begin
            last_grant <= grant_idx;
            if (sel_rd != '0) begin
               wr_id_q   <= sel_rd;
               wr_data_q <= sel_data;
            end
         end
      end
   end

   // A claim is applied after the clear so a newer producer on the same register keeps it busy.
   always_comb begin
      busy_next = busy;
      if (wr_en_q) begin
         busy_next[wr_id_q] = 1'b0;
      end
      if (bus.claim_valid && (bus.claim_rd != '0)) begin
         busy_next[bus.claim_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   assign bus.rs1_busy = busy[bus.query_rs1] && !(wr_en_q && (wr_id_q == bus.query_rs1));
   assign bus.rs2_busy = busy[bus.query_rs2] && !(wr_en_q && (wr_id_q == bus.query_rs2));
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_id    = wr_id_q;
   assign bus.wr_data  = wr_data_q;
endmodule
